led_edge_ctrl: RTL and testbench
================================

Name: led_edge_ctrl

Overview:
- Multi-channel LED controller driven directly by raw key/level inputs, one LED per channel.
- Per channel: 2-flop synchroniser, rise/fall edge detector, LED action unit.
- LED action is chosen at run time: toggle on rise, toggle on fall, toggle on either edge, or retriggerable pulse-stretch.
- Sits after the input filter stage and drives board LEDs; it is the parametrised successor of the two-channel edge-toggle LED block.

Parameters:
- CH, 4, number of independent channels (>=1).
- STRETCH_CYC, 50_000_000, LED on-time in clk cycles for pulse-stretch mode (>=1).
- INIT_LEVEL, 1'b1, reset value of every synchroniser/history flop (idle key level); prevents a false edge after reset.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- key_in  input  CH  raw asynchronous inputs, one per channel.
- mode  input  2  global action select: 0 toggle-on-rise, 1 toggle-on-fall, 2 toggle-on-both, 3 pulse-stretch on rise; synchronous to clk.
- led  output  CH  LED drive, 1 = on.
- rise_pulse  output  CH  one-cycle pulse per detected rising edge (all modes).
- fall_pulse  output  CH  one-cycle pulse per detected falling edge (all modes).

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low; all flops clear on negedge rst_n.
- Reset values:
  - sync stage 1, sync stage 2 and history flop = INIT_LEVEL for all channels.
  - led = 0, stretch counters = 0, mode_q = 0.
  - rise_pulse = fall_pulse = 0 (guaranteed because all history flops are equal).
- Synchroniser per channel: s1 <= key_in; s2 <= s1; h <= s2.
  - rise_pulse = s2 & ~h; fall_pulse = ~s2 & h.
  - Both are combinational from flops, so they are glitch-free.
- Latency: key_in settles high before clock edge k. Then s1 = 1 after edge k, s2 = 1 after k+1, rise_pulse high from k+1 to k+2, and led acts at edge k+2.
- Pulse width: exactly one cycle per input transition. An input held for any length gives a single pulse.
- Input glitches shorter than one clock period may be missed; that is acceptable, no filtering here.
- Mode 0/1/2 (toggle): led[i] <= ~led[i] on the selected edge(s); otherwise hold. In mode 2, rise and fall can never coincide on one channel.
- Mode 3 (pulse-stretch), per channel down-counter cnt, width $clog2(STRETCH_CYC+1):
  - rise_pulse: cnt <= STRETCH_CYC, led <= 1. This is a retrigger: an edge while already counting reloads to full.
  - else if cnt > 1: cnt <= cnt-1, led holds 1.
  - else if cnt == 1: cnt <= 0, led <= 0.
  - else: hold 0.
  - Result: led is high for exactly STRETCH_CYC cycles after the last rise. fall_pulse has no effect.
- Mode change:
  - mode_q registers mode every cycle; mode_chg = (mode != mode_q).
  - In a mode_chg cycle, every led <= 0 and every cnt <= 0, and edge actions in that cycle are discarded.
  - The new mode acts from the following cycle.
  - rise_pulse/fall_pulse outputs are unaffected by mode.
- Channels are fully independent. Simultaneous edges on different channels are all serviced in the same cycle.
- Reset mid-stretch: counter and led clear immediately (asynchronously). No edge is generated on release, provided key_in is at INIT_LEVEL.
- Counter never wraps: it decrements only when > 0, and reload saturates at STRETCH_CYC.

Decomposition:
- Shared package led_pkg:
  - mode encodings MODE_RISE=2'd0, MODE_FALL=2'd1, MODE_BOTH=2'd2, MODE_STRETCH=2'd3.
  - a function computing the counter width.
- One natural sub-module, edge_sync_det: one-channel synchroniser plus edge detector, params INIT_LEVEL, outputs rise/fall. Instantiated CH times via generate.
- LED action logic lives in the top level, one generate loop per channel.

Test Plan:
1. Reset release with key_in = all 1, mode 0, hold 20 cycles -> led = 0, no rise/fall pulses at any cycle.
2. Mode 0, CH=4, STRETCH_CYC=8; key_in[0] 1->0->1 (low 5 cycles) -> fall_pulse[0] one cycle, rise_pulse[0] one cycle 2 cycles after the input rise, led[0] 0->1 at the next edge. Second press -> led[0] back to 0. Other LEDs stay 0.
3. Mode 2, key_in[1] toggled 3 times -> led[1] toggles 3 times, final 1. Mode 1 same stimulus -> toggles only on falls.
4. Mode 3, STRETCH_CYC=8, single rise on ch2 -> led[2] high exactly 8 cycles. Second rise at cycle 5 of the count -> led high 8 cycles from the second rise (12 total).
5. Mode 0 with led = 4'b1010, then switch mode to 3 -> all led = 0 in the cycle after the switch. An edge presented in the switch cycle is ignored; the next rise stretches normally.
6. rst_n asserted mid-stretch asynchronously (between clock edges) -> led and counters 0 immediately. Release with key_in idle -> no spurious pulse, led stays 0.

Source files
------------

// File: rtl/led_pkg.sv
// led_pkg: shared mode encodings and counter sizing for the LED edge controller
package led_pkg;
    typedef enum logic [1:0] {
        MODE_RISE    = 2'd0,
        MODE_FALL    = 2'd1,
        MODE_BOTH    = 2'd2,
        MODE_STRETCH = 2'd3
    } mode_e;

    function automatic int cnt_width(input int stretch_cyc);
        return $clog2(stretch_cyc + 1);
    endfunction
endpackage

// File: rtl/edge_sync_det.sv
// edge_sync_det: two-flop synchroniser plus history flop giving one-cycle rise/fall pulses
module edge_sync_det #(
    parameter logic INIT_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic rise,
    output logic fall
);
    logic s1_d, s2_d, h_d;
    logic s1_q, s2_q, h_q;
    // shift the raw input through the synchroniser and into the history flop
    always_comb begin
        s1_d = key_in;
        s2_d = s1_q;
        h_d  = s2_q;
    end
    // idle level on reset so no edge appears when reset releases
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= INIT_LEVEL;
            s2_q <= INIT_LEVEL;
            h_q  <= INIT_LEVEL;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            h_q  <= h_d;
        end
    end
    assign rise = s2_q & ~h_q;
    assign fall = ~s2_q & h_q;
endmodule

// File: rtl/led_edge_ctrl.sv
// led_edge_ctrl: per-channel synchronised edge detection driving LEDs in toggle or pulse-stretch mode
module led_edge_ctrl
    import led_pkg::*;
#(
    parameter int   CH          = 4,
    parameter int   STRETCH_CYC = 50_000_000,
    parameter logic INIT_LEVEL  = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] key_in,
    input  logic [1:0]    mode,
    output logic [CH-1:0] led,
    output logic [CH-1:0] rise_pulse,
    output logic [CH-1:0] fall_pulse
);
    localparam int CW = cnt_width(STRETCH_CYC);
    localparam logic [CW-1:0] CNT_MAX = CW'(STRETCH_CYC);
    mode_e mode_d, mode_q;
    logic  mode_chg;
    // any mode change clears every channel for one cycle before the new mode acts
    always_comb begin
        mode_d   = mode_e'(mode);
        mode_chg = mode_d != mode_q;
    end
    // registered copy of the mode select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mode_q <= MODE_RISE;
        else        mode_q <= mode_d;
    end
    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic          rise, fall, tog, led_d, led_q;
        logic [CW-1:0] cnt_d, cnt_q;
        edge_sync_det #(.INIT_LEVEL(INIT_LEVEL)) u_det (
            .clk   (clk),
            .rst_n (rst_n),
            .key_in(key_in[i]),
            .rise  (rise),
            .fall  (fall)
        );
        assign rise_pulse[i] = rise;
        assign fall_pulse[i] = fall;
        assign led[i]        = led_q;
        // toggle on the selected edge, or retriggerable stretch that reloads on every rise
        always_comb begin
            tog   = mode_q == MODE_BOTH ? (rise | fall) : mode_q == MODE_FALL ? fall : rise;
            led_d = led_q;
            cnt_d = cnt_q;
            if (mode_chg) begin
                led_d = 1'b0;
                cnt_d = '0;
            end else if (mode_q == MODE_STRETCH) begin
                if (rise) begin
                    led_d = 1'b1;
                    cnt_d = CNT_MAX;
                end else if (cnt_q > CW'(1)) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (cnt_q == CW'(1)) begin
                    led_d = 1'b0;
                    cnt_d = '0;
                end
            end else if (tog) begin
                led_d = ~led_q;
            end
        end
        // LED and stretch counter state
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                led_q <= 1'b0;
                cnt_q <= '0;
            end else begin
                led_q <= led_d;
                cnt_q <= cnt_d;
            end
        end
    end
endmodule

// File: tb/tb_led_edge_ctrl.sv
// tb_led_edge_ctrl: scenario tasks checked against a timestamp-based behavioural model
module tb_led_edge_ctrl;
    localparam int CH = 4;
    localparam int S  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] key_in = '1;
    logic [1:0]    mode = 2'd0;
    logic [CH-1:0] led, rise_pulse, fall_pulse;

    int checks = 0;
    int errs   = 0;

    led_edge_ctrl #(.CH(CH), .STRETCH_CYC(S), .INIT_LEVEL(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .mode      (mode),
        .led       (led),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
    );

    always #5 clk = ~clk;

    // model: key seen two/three edges ago gives the pulses; stretch LED is on while
    // fewer than S edges have passed since the last rise that acted
    logic [CH-1:0] kh0, kh1, kh2, tled, on_ok, pr, pf, m_rise, m_fall;
    logic [1:0]    m_mode;
    int            n;
    int            last_on [CH];

    assign m_rise = kh1 & ~kh2;
    assign m_fall = ~kh1 & kh2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kh0 = '1; kh1 = '1; kh2 = '1;
            tled = '0; on_ok = '0; m_mode = 2'd0; n = 0;
            for (int c = 0; c < CH; c++) last_on[c] = 0;
        end else begin
            pr = kh1 & ~kh2;
            pf = ~kh1 & kh2;
            n++;
            for (int c = 0; c < CH; c++) begin
                if (mode != m_mode) begin
                    tled[c]  = 1'b0;
                    on_ok[c] = 1'b0;
                end else if (m_mode == 2'd3) begin
                    if (pr[c]) begin
                        last_on[c] = n;
                        on_ok[c]   = 1'b1;
                    end
                end else if ((m_mode == 2'd0 && pr[c]) || (m_mode == 2'd1 && pf[c]) ||
                             (m_mode == 2'd2 && (pr[c] || pf[c]))) begin
                    tled[c] = ~tled[c];
                end
            end
            m_mode = mode;
            kh2 = kh1; kh1 = kh0; kh0 = key_in;
        end
    end

    function automatic logic [CH-1:0] exp_led();
        logic [CH-1:0] r;
        for (int c = 0; c < CH; c++)
            r[c] = (m_mode == 2'd3) ? (on_ok[c] && (n - last_on[c]) < S) : tled[c];
        return r;
    endfunction

    task automatic test_reset();
        #1;
        checks++;
        if ({led, rise_pulse, fall_pulse} !== '0) begin
            errs++;
            $display("FAIL reset_hold: led=%b rise=%b fall=%b want all 0", led, rise_pulse, fall_pulse);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 20; s++) begin
            @(negedge clk);
            checks++;
            if ({led, rise_pulse, fall_pulse} !== '0 || exp_led() !== '0) begin
                errs++;
                $display("FAIL reset_idle: led=%b rise=%b fall=%b want all 0", led, rise_pulse, fall_pulse);
            end
        end
    endtask

    task automatic test_toggle_rise();
        int nf = 0;
        for (int p = 0; p < 2; p++) begin
            key_in[0] = 1'b0;
            for (int s = 0; s < 5; s++) begin
                @(negedge clk);
                checks++;
                if ({led, rise_pulse, fall_pulse} !== {exp_led(), m_rise, m_fall}) begin
                    errs++;
                    $display("FAIL toggle_low: led=%b rise=%b fall=%b want led=%b rise=%b fall=%b", led, rise_pulse, fall_pulse, exp_led(), m_rise, m_fall);
                end
                nf += fall_pulse[0];
            end
            key_in[0] = 1'b1;
            for (int s = 1; s <= 5; s++) begin
                @(negedge clk);
                checks++;
                if ({led, rise_pulse, fall_pulse} !== {exp_led(), m_rise, m_fall}) begin
                    errs++;
                    $display("FAIL toggle_high: led=%b rise=%b fall=%b want led=%b rise=%b fall=%b", led, rise_pulse, fall_pulse, exp_led(), m_rise, m_fall);
                end
                if (s <= 2) begin
                    checks++;
                    if (rise_pulse[0] !== (s == 2)) begin
                        errs++;
                        $display("FAIL rise_latency: sample %0d rise0=%b want %b", s, rise_pulse[0], s == 2);
                    end
                end
            end
            checks++;
            if (led !== {3'b000, p == 0}) begin
                errs++;
                $display("FAIL toggle_press%0d: led=%b want %b", p, led, {3'b000, p == 0});
            end
        end
        checks++;
        if (nf != 2) begin
            errs++;
            $display("FAIL fall_count: got %0d want 2", nf);
        end
    endtask

    task automatic test_both_fall();
        for (int m = 0; m < 2; m++) begin
            mode = m == 0 ? 2'd2 : 2'd1;
            key_in[1] = 1'b1;
            for (int t = 0; t < 4; t++) begin
                if (t > 0) key_in[1] = ~key_in[1];
                for (int s = 0; s < 4; s++) begin
                    @(negedge clk);
                    checks++;
                    if ({led, rise_pulse, fall_pulse} !== {exp_led(), m_rise, m_fall}) begin
                        errs++;
                        $display("FAIL both_fall m%0d: led=%b rise=%b fall=%b want led=%b rise=%b fall=%b", mode, led, rise_pulse, fall_pulse, exp_led(), m_rise, m_fall);
                    end
                end
            end
            checks++;
            if (led[1] !== (m == 0)) begin
                errs++;
                $display("FAIL final_led1 mode%0d: led1=%b want %b", mode, led[1], m == 0);
            end
        end
        key_in[1] = 1'b1;
    endtask

    task automatic test_stretch();
        int hi;
        mode = 2'd3;
        key_in[2] = 1'b0;
        for (int p = 0; p < 2; p++) begin
            hi = 0;
            for (int s = 0; s < 3; s++) @(negedge clk);
            key_in[2] = 1'b1;
            for (int s = 1; s <= 20; s++) begin
                @(negedge clk);
                checks++;
                if ({led, rise_pulse, fall_pulse} !== {exp_led(), m_rise, m_fall}) begin
                    errs++;
                    $display("FAIL stretch: led=%b rise=%b fall=%b want led=%b rise=%b fall=%b", led, rise_pulse, fall_pulse, exp_led(), m_rise, m_fall);
                end
                hi += led[2];
                if (p == 1 && s == 3) key_in[2] = 1'b0;
                if (p == 1 && s == 4) key_in[2] = 1'b1;
            end
            checks++;
            if (hi != (p == 0 ? S : S + 4)) begin
                errs++;
                $display("FAIL stretch_width%0d: high %0d cycles want %0d", p, hi, p == 0 ? S : S + 4);
            end
            key_in[2] = 1'b0;
        end
        key_in[2] = 1'b1;
        for (int s = 0; s < 4; s++) @(negedge clk);
    endtask

    task automatic test_mode_switch();
        mode = 2'd0;
        for (int s = 0; s < 3; s++) @(negedge clk);
        key_in = 4'b0101;
        for (int s = 0; s < 3; s++) @(negedge clk);
        key_in = 4'b1111;
        for (int s = 0; s < 4; s++) @(negedge clk);
        checks++;
        if (led !== 4'b1010) begin
            errs++;
            $display("FAIL pre_switch: led=%b want 1010", led);
        end
        key_in[0] = 1'b0;
        for (int s = 0; s < 3; s++) @(negedge clk);
        key_in[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mode = 2'd3;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            checks++;
            if (led !== 4'b0000 || exp_led() !== 4'b0000) begin
                errs++;
                $display("FAIL switch_clear: led=%b want 0000", led);
            end
        end
        key_in[0] = 1'b0;
        for (int s = 0; s < 3; s++) @(negedge clk);
        key_in[0] = 1'b1;
        for (int s = 1; s <= 12; s++) begin
            @(negedge clk);
            checks++;
            if ({led, rise_pulse, fall_pulse} !== {exp_led(), m_rise, m_fall}) begin
                errs++;
                $display("FAIL post_switch: led=%b rise=%b fall=%b want led=%b rise=%b fall=%b", led, rise_pulse, fall_pulse, exp_led(), m_rise, m_fall);
            end
            if (s == 3) begin
                checks++;
                if (led[0] !== 1'b1) begin
                    errs++;
                    $display("FAIL post_switch_on: led0=%b want 1", led[0]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        key_in[2] = 1'b0;
        for (int s = 0; s < 3; s++) @(negedge clk);
        key_in[2] = 1'b1;
        for (int s = 0; s < 5; s++) @(negedge clk);
        checks++;
        if (led[2] !== 1'b1) begin
            errs++;
            $display("FAIL pre_reset_on: led2=%b want 1", led[2]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (led !== '0 || exp_led() !== '0) begin
            errs++;
            $display("FAIL async_clear: led=%b want 0000", led);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 12; s++) begin
            @(negedge clk);
            checks++;
            if ({led, rise_pulse, fall_pulse} !== '0) begin
                errs++;
                $display("FAIL post_reset_idle: led=%b rise=%b fall=%b want all 0", led, rise_pulse, fall_pulse);
            end
        end
    endtask

    task automatic test_back_to_back();
        mode = 2'd2;
        for (int s = 0; s < 3; s++) @(negedge clk);
        key_in = '0;
        for (int s = 0; s < 3; s++) @(negedge clk);
        key_in = '1;
        for (int s = 1; s <= 4; s++) begin
            @(negedge clk);
            checks++;
            if ({led, rise_pulse, fall_pulse} !== {exp_led(), m_rise, m_fall}) begin
                errs++;
                $display("FAIL b2b: led=%b rise=%b fall=%b want led=%b rise=%b fall=%b", led, rise_pulse, fall_pulse, exp_led(), m_rise, m_fall);
            end
            if (s == 2) begin
                checks++;
                if (rise_pulse !== 4'hF) begin
                    errs++;
                    $display("FAIL b2b_all_rise: rise=%b want 1111", rise_pulse);
                end
            end
        end
        checks++;
        if (led !== 4'b0000) begin
            errs++;
            $display("FAIL b2b_led: led=%b want 0000", led);
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 600; s++) begin
            @(negedge clk);
            checks++;
            if ({led, rise_pulse, fall_pulse} !== {exp_led(), m_rise, m_fall}) begin
                errs++;
                $display("FAIL random@%0d: led=%b rise=%b fall=%b want led=%b rise=%b fall=%b", s, led, rise_pulse, fall_pulse, exp_led(), m_rise, m_fall);
            end
            if ($urandom_range(3) == 0) key_in[$urandom_range(CH - 1)] ^= 1'b1;
            if ($urandom_range(59) == 0) mode = 2'($urandom_range(3));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_toggle_rise();
        test_both_fall();
        test_stretch();
        test_mode_switch();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end
endmodule
